// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, H/V counters, pixel request and a
// latency-matched sync/DE/colour output pipeline. Define VGA_TEST_PATTERN_EN for 8 colour bars.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned HS_POL   = 0,
   parameter int unsigned VS_POL   = 0,
   parameter int unsigned COLOR_W  = 1,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic                   sysclk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [3*COLOR_W-1:0]   pixel_data,
   output logic [10:0]            pixel_x,
   output logic [9:0]             pixel_y,
   output logic                   pixel_req,
   output logic [COLOR_W-1:0]     VGA_R,
   output logic [COLOR_W-1:0]     VGA_G,
   output logic [COLOR_W-1:0]     VGA_B,
   output logic                   VGA_HS,
   output logic                   VGA_VS,
   output logic                   VGA_DE,
   output logic                   frame_start,
   output logic                   pix_tick
);
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned PW = 7;
`else
   localparam int unsigned PW = 4;
`endif

   // pipeline word: {[bar,] sof, de, vs, hs}; stage 0 is aligned with the request registers
   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic [10:0]          h_cnt_q, h_cnt_d, x_q, x_d;
   logic [9:0]           v_cnt_q, v_cnt_d, y_q, y_d;
   logic                 req_q, req_d;
   logic [PW-1:0]        dly_q [RD_LAT+1];
   logic [PW-1:0]        dly_d [RD_LAT+1];
   logic                 hs_o_q, hs_o_d, vs_o_q, vs_o_d, de_o_q, de_o_d, sof_o_q, sof_o_d;
   logic [3*COLOR_W-1:0] rgb_o_q, rgb_o_d;
   logic                 tick;
   logic                 h_act, v_act, hs_raw, vs_raw;
   logic [PW-1:0]        word_in, word_out;
   logic [3*COLOR_W-1:0] colour;

   always_comb begin
      tick   = enable && (div_cnt_q == DIV_W'(CLK_DIV - 1));
      h_act  = h_cnt_q < 11'(H_ACTIVE);
      v_act  = v_cnt_q < 10'(V_ACTIVE);
      hs_raw = (h_cnt_q >= 11'(HS_START)) && (h_cnt_q < 11'(HS_START + H_SYNC));
      vs_raw = (v_cnt_q >= 10'(VS_START)) && (v_cnt_q < 10'(VS_START + V_SYNC));
      word_out = dly_q[RD_LAT];
`ifdef VGA_TEST_PATTERN_EN
      word_in = {3'((32'(h_cnt_q) * 32'd8) / H_ACTIVE),
                 (h_cnt_q == '0) && (v_cnt_q == '0), h_act && v_act, vs_raw, hs_raw};
      colour  = {{COLOR_W{word_out[6]}}, {COLOR_W{word_out[5]}}, {COLOR_W{word_out[4]}}};
`else
      word_in = {(h_cnt_q == '0) && (v_cnt_q == '0), h_act && v_act, vs_raw, hs_raw};
      colour  = pixel_data;
`endif
   end

`ifdef VGA_TEST_PATTERN_EN
   logic pixel_data_unused;
   assign pixel_data_unused = ^pixel_data;
`endif

   always_comb begin
      div_cnt_d = div_cnt_q;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      req_d     = req_q;
      x_d       = x_q;
      y_d       = y_q;
      dly_d     = dly_q;
      hs_o_d    = hs_o_q;
      vs_o_d    = vs_o_q;
      de_o_d    = de_o_q;
      sof_o_d   = sof_o_q;
      rgb_o_d   = rgb_o_q;
      if (!enable) begin
         div_cnt_d = '0;
         h_cnt_d   = '0;
         v_cnt_d   = '0;
         req_d     = 1'b0;
         x_d       = '0;
         y_d       = '0;
         for (int unsigned k = 0; k <= RD_LAT; k++) dly_d[k] = '0;
         hs_o_d    = 1'b0;
         vs_o_d    = 1'b0;
         de_o_d    = 1'b0;
         sof_o_d   = 1'b0;
         rgb_o_d   = '0;
      end else if (tick) begin
         div_cnt_d = '0;
         if (h_cnt_q == 11'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == 10'(V_TOTAL - 1)) ? '0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 11'd1;
         end
         req_d    = h_act && v_act;
         x_d      = (h_act && v_act) ? h_cnt_q : '0;
         y_d      = (h_act && v_act) ? v_cnt_q : '0;
         dly_d[0] = word_in;
         for (int unsigned k = 1; k <= RD_LAT; k++) dly_d[k] = dly_q[k-1];
         hs_o_d   = word_out[0];
         vs_o_d   = word_out[1];
         de_o_d   = word_out[2];
         sof_o_d  = word_out[3];
         rgb_o_d  = word_out[2] ? colour : '0;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         req_q     <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         for (int unsigned k = 0; k <= RD_LAT; k++) dly_q[k] <= '0;
         hs_o_q    <= 1'b0;
         vs_o_q    <= 1'b0;
         de_o_q    <= 1'b0;
         sof_o_q   <= 1'b0;
         rgb_o_q   <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         req_q     <= req_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dly_q     <= dly_d;
         hs_o_q    <= hs_o_d;
         vs_o_q    <= vs_o_d;
         de_o_q    <= de_o_d;
         sof_o_q   <= sof_o_d;
         rgb_o_q   <= rgb_o_d;
      end
   end

   assign pixel_x     = x_q;
   assign pixel_y     = y_q;
   assign pixel_req   = req_q;
   assign VGA_R       = rgb_o_q[3*COLOR_W-1 -: COLOR_W];
   assign VGA_G       = rgb_o_q[2*COLOR_W-1 -: COLOR_W];
   assign VGA_B       = rgb_o_q[COLOR_W-1 -: COLOR_W];
   assign VGA_HS      = hs_o_q ? 1'(HS_POL) : ~1'(HS_POL);
   assign VGA_VS      = vs_o_q ? 1'(VS_POL) : ~1'(VS_POL);
   assign VGA_DE      = de_o_q;
   // sof_o_q holds for a whole pixel period; qualify with the tick for a one-sysclk pulse
   assign frame_start = sof_o_q & tick;
   assign pix_tick    = tick;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen with a small raster: expected pin words are queued
// per pixel tick and compared once the output pipeline presents them.
module tb_vga_timing_gen;
   localparam int unsigned CLK_DIV  = 3;
   localparam int unsigned H_ACTIVE = 16;
   localparam int unsigned H_FP     = 2;
   localparam int unsigned H_SYNC   = 3;
   localparam int unsigned H_BP     = 3;
   localparam int unsigned V_ACTIVE = 6;
   localparam int unsigned V_FP     = 1;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 1;
   localparam int unsigned HS_POL   = 0;
   localparam int unsigned VS_POL   = 1;
   localparam int unsigned RD_LAT   = 3;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned FRAME_CYC = H_TOTAL * V_TOTAL * CLK_DIV;
   localparam logic HSP = (HS_POL != 0);
   localparam logic VSP = (VS_POL != 0);

   logic        sysclk = 1'b0;
   logic        rst_n  = 1'b0;
   logic        enable = 1'b1;
   logic [2:0]  pixel_data;
   logic [10:0] pixel_x;
   logic [9:0]  pixel_y;
   logic        pixel_req;
   logic [0:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS, VGA_DE, frame_start, pix_tick;

   always #5 sysclk = ~sysclk;

   vga_timing_gen #(
      .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(HS_POL), .VS_POL(VS_POL), .COLOR_W(1), .RD_LAT(RD_LAT)
   ) dut (
      .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .pixel_data(pixel_data),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_req(pixel_req),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_DE(VGA_DE), .frame_start(frame_start), .pix_tick(pix_tick)
   );

   // frame source: {x[0], y[0], 1} returned RD_LAT ticks after the request, junk between ticks
   logic [2:0] src_q [RD_LAT];
   logic [2:0] junk;
   always @(posedge sysclk) begin
      if (pix_tick) begin
         src_q[0] <= {pixel_x[0], pixel_y[0], 1'b1};
         for (int i = 1; i < int'(RD_LAT); i++) src_q[i] <= src_q[i-1];
      end
   end
   always @(negedge sysclk) junk <= 3'($urandom);
   assign pixel_data = pix_tick ? src_q[RD_LAT-1] : junk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   int unsigned m_h, m_v, cyc;
   logic [6:0]  pin_q [$];
   logic [31:0] req_exp;
   bit          run = 1'b0;

   function automatic logic [6:0] idle_pins();
      return {~HSP, ~VSP, 1'b0, 3'b000, 1'b0};
   endfunction

   function automatic logic [6:0] model_pins(input int unsigned h, input int unsigned v);
      logic hs, vs, de;
      logic [2:0]  rgb;
      logic [31:0] bar;
      hs  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
      vs  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
      de  = (h < H_ACTIVE) && (v < V_ACTIVE);
      bar = (h * 8) / H_ACTIVE;
`ifdef VGA_TEST_PATTERN_EN
      rgb = de ? bar[2:0] : 3'b000;
`else
      rgb = de ? {h[0], v[0], 1'b1} : 3'b000;
`endif
      return {hs ? HSP : ~HSP, vs ? VSP : ~VSP, de, rgb, (h == 0) && (v == 0)};
   endfunction

   function automatic logic [31:0] model_req(input int unsigned h, input int unsigned v);
      if ((h < H_ACTIVE) && (v < V_ACTIVE)) return {10'd0, 1'b1, 11'(h), 10'(v)};
      return '0;
   endfunction

   task automatic restart();
      m_h = 0;
      m_v = 0;
      pin_q.delete();
      repeat (RD_LAT + 2) pin_q.push_back(idle_pins());
      req_exp = '0;
      cyc = 1;
      run = 1'b1;
   endtask

   task automatic monitor();
      logic [6:0] got, exp;
      logic       et;
      got = {VGA_HS, VGA_VS, VGA_DE, VGA_R, VGA_G, VGA_B, frame_start};
      if (!run) begin
         check("idle_pins", 32'(got), 32'(idle_pins()));
         check("idle_tick", 32'(pix_tick), 32'd0);
         check("idle_req", {10'd0, pixel_req, pixel_x, pixel_y}, 32'd0);
      end else begin
         cyc++;
         et = (cyc == CLK_DIV);
         check("pix_tick", 32'(pix_tick), 32'(et));
         exp = pin_q[0];
         if (!et) exp[0] = 1'b0;
         check("pins", 32'(got), 32'(exp));
         check("req", {10'd0, pixel_req, pixel_x, pixel_y}, req_exp);
         if (et) begin
            void'(pin_q.pop_front());
            pin_q.push_back(model_pins(m_h, m_v));
            req_exp = model_req(m_h, m_v);
            if (m_h == H_TOTAL - 1) begin
               m_h = 0;
               m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
            end else begin
               m_h++;
            end
            cyc = 0;
         end
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(negedge sysclk);
         monitor();
      end
   endtask

   initial begin
      // reset held with the clock running and enable high
      step(6);
      rst_n = 1'b1;
      restart();
      step(2 * FRAME_CYC + 50);

      // drop enable mid-frame
      begin
         int unsigned guard;
         guard = 0;
         while (!(m_v == 3 && m_h == 5) && guard < 2 * FRAME_CYC) begin
            step(1);
            guard++;
         end
         check("reach_drop_point", 32'(m_v == 3 && m_h == 5), 32'd1);
      end
      enable = 1'b0;
      run    = 1'b0;
      step(20);
      enable = 1'b1;
      restart();
      step(FRAME_CYC + 100);

      // asynchronous reset between clock edges
      @(posedge sysclk);
      #2;
      rst_n = 1'b0;
      run   = 1'b0;
      #1;
      monitor();
      step(5);
      rst_n = 1'b1;
      restart();
      step(FRAME_CYC / 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
